// File: rtl/axi_llc_pkg.sv
// ---------------------------------------------------------------------------
// axi_llc_pkg
// Shared types and helpers for the LLC flush sequencer.
//   flush_state_e : sequencer state encoding (IDLE, ISSUE, DRAIN, DONE)
//   idx_width()   : bit width needed to index n items (never below 1)
// ---------------------------------------------------------------------------
package axi_llc_pkg;

    typedef enum logic [1:0] {
        FLUSH_IDLE  = 2'd0,
        FLUSH_ISSUE = 2'd1,
        FLUSH_DRAIN = 2'd2,
        FLUSH_DONE  = 2'd3
    } flush_state_e;

    // A single way still needs a 1-bit index signal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lzc.sv
// ---------------------------------------------------------------------------
// lzc
// Finds the index of the lowest set bit of a vector.
//   in_i    : vector to search
//   idx_o   : index of the lowest set bit (0 when the vector is empty)
//   empty_o : no bit of in_i is set
// ---------------------------------------------------------------------------
module lzc
    import axi_llc_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic [Width-1:0]            in_i,
    output logic [idx_width(Width)-1:0] idx_o,
    output logic                        empty_o
);

    localparam int CntW = int'(idx_width(Width));

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        idx_o   = '0;
        empty_o = 1'b1;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = Width - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o   = CntW'(i);
                empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_llc_flush_seq.sv
// ---------------------------------------------------------------------------
// axi_llc_flush_seq
// Walks every line of every selected data way, line-major, issuing one read
// request per (line, way) so the evict path can write the contents back.
//   clk_i, rst_i     : clock (rising edge), asynchronous active-high reset
//   start_i          : flush start pulse, accepted only while idle
//   way_mask_i       : ways to flush, sampled on an accepted start
//   req_valid_o      : read request valid (AXI-style valid/ready)
//   req_ready_i      : crossbar accepts the request
//   req_way_ind_o    : one-hot target way of the request
//   req_line_o       : line index of the request
//   rsp_i            : one read response consumed this cycle
//   busy_o           : sequencer not idle
//   done_o           : one-cycle completion pulse
//   err_o            : sticky, a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module axi_llc_flush_seq
    import axi_llc_pkg::*;
#(
    parameter int SetAssociativity = 8,
    parameter int NumLines         = 256,
    parameter int MaxOutstanding   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [SetAssociativity-1:0]   way_mask_i,
    output logic                          req_valid_o,
    input  logic                          req_ready_i,
    output logic [SetAssociativity-1:0]   req_way_ind_o,
    output logic [$clog2(NumLines)-1:0]   req_line_o,
    input  logic                          rsp_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int WayW  = int'(idx_width(SetAssociativity));
    localparam int LineW = $clog2(NumLines);
    localparam int OutW  = $clog2(MaxOutstanding + 1);

    localparam logic [OutW-1:0]             MaxOut   = OutW'(MaxOutstanding);
    localparam logic [LineW-1:0]            LastLine = LineW'(NumLines - 1);
    localparam logic [SetAssociativity-1:0] WayOne   = SetAssociativity'(1);

    flush_state_e                state_q;
    logic [SetAssociativity-1:0] mask_q;
    logic [WayW-1:0]             way_q;        // way currently presented
    logic [WayW-1:0]             first_way_q;  // lowest masked way, wrap target
    logic [LineW-1:0]            line_q;
    logic [OutW-1:0]             out_q;
    logic [OutW-1:0]             out_nxt;
    logic                        req_valid_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_q;

    logic [SetAssociativity-1:0] search_vec;
    logic [WayW-1:0]             srch_idx;
    logic                        srch_empty;
    logic                        hs;
    logic                        spurious;
    logic                        last_req;

    // While idle the search yields the first way of the incoming mask; while
    // issuing it yields the next masked way above the current one, and an
    // empty result means the line is finished and the walk wraps.
    always_comb begin
        search_vec = '0;
        for (int i = 0; i < SetAssociativity; i++) begin
            if (state_q == FLUSH_IDLE) search_vec[i] = way_mask_i[i];
            else                       search_vec[i] = mask_q[i] && (i > int'(way_q));
        end
    end

    lzc #(
        .Width (SetAssociativity)
    ) u_lzc (
        .in_i    (search_vec),
        .idx_o   (srch_idx),
        .empty_o (srch_empty)
    );

    assign hs       = req_valid_q && req_ready_i;
    assign spurious = rsp_i && !hs && (out_q == '0);
    assign last_req = srch_empty && (line_q == LastLine);

    // A handshake and a response in the same cycle cancel out; a response
    // with nothing outstanding saturates at zero and is flagged instead.
    always_comb begin
        out_nxt = out_q;
        if (hs && !rsp_i)                        out_nxt = out_q + OutW'(1);
        else if (!hs && rsp_i && out_q != '0)    out_nxt = out_q - OutW'(1);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    // NOTE: every register is reset; there is no storage array here whose
    // contents could be left unreset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= FLUSH_IDLE;
            mask_q      <= '0;
            way_q       <= '0;
            first_way_q <= '0;
            line_q      <= '0;
            out_q       <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_q <= out_nxt;
            if (spurious) err_q <= 1'b1;

            case (state_q)
                FLUSH_IDLE: begin
                    if (start_i) begin
                        mask_q      <= way_mask_i;
                        way_q       <= srch_idx;
                        first_way_q <= srch_idx;
                        line_q      <= '0;
                        err_q       <= 1'b0;   // a new flush wins over a stale flag
                        busy_q      <= 1'b1;
                        if (srch_empty) begin
                            state_q <= FLUSH_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= FLUSH_ISSUE;
                            req_valid_q <= (out_nxt < MaxOut);
                        end
                    end
                end

                FLUSH_ISSUE: begin
                    if (hs) begin
                        if (!srch_empty) begin
                            way_q <= srch_idx;
                        end else begin
                            way_q  <= first_way_q;
                            line_q <= line_q + LineW'(1);
                        end
                        if (last_req) begin
                            state_q     <= FLUSH_DRAIN;
                            req_valid_q <= 1'b0;
                        end else begin
                            req_valid_q <= (out_nxt < MaxOut);
                        end
                    end else if (!req_valid_q) begin
                        // A raised valid is held until accepted; only a low
                        // valid looks at the outstanding limit.
                        req_valid_q <= (out_nxt < MaxOut);
                    end
                end

                FLUSH_DRAIN: begin
                    if (out_q == '0) begin
                        state_q <= FLUSH_DONE;
                        done_q  <= 1'b1;
                    end
                end

                FLUSH_DONE: begin
                    state_q <= FLUSH_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end

                default: state_q <= FLUSH_IDLE;
            endcase
        end
    end

    assign req_valid_o   = req_valid_q;
    assign req_way_ind_o = (state_q == FLUSH_ISSUE) ? (WayOne << way_q) : '0;
    assign req_line_o    = (state_q == FLUSH_ISSUE) ? line_q : '0;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_axi_llc_flush_seq.sv
// ---------------------------------------------------------------------------
// tb_axi_llc_flush_seq
// Scoreboard bench for the LLC flush sequencer. On every accepted start the
// reference model enumerates the expected (way, line) requests in line-major
// order into a queue; an independent monitor pops and compares on every
// handshake and tracks outstanding requests, the error flag, busy and the
// completion pulse from the behavioural rules.
// ---------------------------------------------------------------------------
module tb_axi_llc_flush_seq;

    localparam int A    = 4;
    localparam int NL   = 4;
    localparam int MAXO = 2;
    localparam int LW   = $clog2(NL);

    typedef struct packed {
        logic [A-1:0]  way;
        logic [LW-1:0] line;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [A-1:0]  way_mask_i = '0;
    logic          req_ready_i = 1'b0;
    logic          rsp_i = 1'b0;
    logic          req_valid_o;
    logic [A-1:0]  req_way_ind_o;
    logic [LW-1:0] req_line_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    req_t exp_q[$];
    int   rsp_due[$];
    int   cyc          = 0;
    int   model_out    = 0;
    bit   err_exp      = 1'b0;
    bit   flush_on     = 1'b0;
    int   exp_done_cyc = -1;
    int   exp_total    = 0;
    int   flush_hs     = 0;
    int   hs_total     = 0;
    bit   prev_valid   = 1'b0;
    bit   prev_ready   = 1'b0;
    req_t prev_req     = '0;

    // Stimulus controls
    int   ready_mode = 0;     // 0: always ready, 1: random, 2: never ready
    bit   rsp_hold   = 1'b0;
    bit   spur_pulse = 1'b0;
    bit   rsp_rand   = 1'b0;
    int   rsp_fixed  = 2;

    axi_llc_flush_seq #(
        .SetAssociativity (A),
        .NumLines         (NL),
        .MaxOutstanding   (MAXO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .way_mask_i    (way_mask_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_way_ind_o (req_way_ind_o),
        .req_line_o    (req_line_o),
        .rsp_i         (rsp_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready driver
    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0:       req_ready_i = 1'b1;
            1:       req_ready_i = ($urandom_range(0, 3) != 0);
            default: req_ready_i = 1'b0;
        endcase
    end

    // Response driver: one response per cycle once due, in request order
    initial forever begin
        @(posedge clk); #1;
        if (rst_i) begin
            rsp_i = 1'b0;
        end else if (spur_pulse) begin
            rsp_i      = 1'b1;
            spur_pulse = 1'b0;
        end else if (!rsp_hold && rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
            rsp_i = 1'b1;
            void'(rsp_due.pop_front());
        end else begin
            rsp_i = 1'b0;
        end
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        req_t got;
        req_t want;
        req_t r;
        bit   hs;
        cyc++;
        if (rst_i) begin
            check("rst_valid", req_valid_o, 0);
            check("rst_way", req_way_ind_o, 0);
            check("rst_line", req_line_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_done", done_o, 0);
            check("rst_err", err_o, 0);
            exp_q.delete();
            rsp_due.delete();
            model_out    = 0;
            err_exp      = 1'b0;
            flush_on     = 1'b0;
            exp_done_cyc = -1;
            prev_valid   = 1'b0;
        end else begin
            check("err", err_o, err_exp);
            check("done", done_o, cyc == exp_done_cyc);
            check("busy", busy_o, flush_on);
            if (req_valid_o) check("out_limit", model_out < MAXO, 1);
            if (prev_valid && !prev_ready) begin
                check("hold_valid", req_valid_o, 1);
                check("hold_payload", {req_way_ind_o, req_line_o}, prev_req);
            end

            hs = req_valid_o && req_ready_i;
            if (hs) begin
                got.way  = req_way_ind_o;
                got.line = req_line_o;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got way %0h line %0d expected none (cycle %0d)",
                             got.way, got.line, cyc);
                end else begin
                    want = exp_q.pop_front();
                    check("req_way", got.way, want.way);
                    check("req_line", got.line, want.line);
                end
                rsp_due.push_back(cyc + (rsp_rand ? int'($urandom_range(1, 5)) : rsp_fixed));
                hs_total++;
                flush_hs++;
            end

            if (hs && !rsp_i) begin
                model_out++;
            end else if (rsp_i && !hs) begin
                if (model_out == 0) err_exp = 1'b1;
                else                model_out--;
            end

            if (start_i && !flush_on) begin
                err_exp   = 1'b0;
                flush_on  = 1'b1;
                flush_hs  = 0;
                exp_total = $countones(way_mask_i) * NL;
                for (int l = 0; l < NL; l++) begin
                    for (int w = 0; w < A; w++) begin
                        if (way_mask_i[w]) begin
                            r      = '0;
                            r.way[w] = 1'b1;
                            r.line = LW'(l);
                            exp_q.push_back(r);
                        end
                    end
                end
                if (way_mask_i == '0) exp_done_cyc = cyc + 1;
            end else if (cyc == exp_done_cyc) begin
                check("req_count", flush_hs, exp_total);
                flush_on     = 1'b0;
                exp_done_cyc = -1;
            end

            // All issued and all answered: done follows two cycles later.
            if (flush_on && exp_done_cyc < 0 && exp_q.size() == 0 && model_out == 0)
                exp_done_cyc = cyc + 2;

            prev_valid    = req_valid_o;
            prev_ready    = req_ready_i;
            prev_req.way  = req_way_ind_o;
            prev_req.line = req_line_o;
        end
    end

    task automatic start_flush(input logic [A-1:0] m);
        @(posedge clk); #1;
        start_i    = 1'b1;
        way_mask_i = m;
        @(posedge clk); #1;
        start_i    = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (flush_on && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("flush_timeout", flush_on, 0);
        @(negedge clk); #1;
    endtask

    initial begin
        int h0;
        int n;

        #1 rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_i = 1'b0;
        @(negedge clk); #1;
        check("idle_valid", req_valid_o, 0);
        check("idle_busy", busy_o, 0);
        check("idle_err", err_o, 0);

        // Basic flush: ways 0 and 2, responses two cycles after each request
        ready_mode = 0;
        rsp_rand   = 1'b0;
        rsp_fixed  = 2;
        start_flush(4'b0101);
        wait_idle(300);

        // Random masks, random ready and response latency; a second start
        // inside each flush must be ignored.
        ready_mode = 1;
        rsp_rand   = 1'b1;
        repeat (6) begin
            start_flush(A'($urandom_range(1, 15)));
            repeat (2) @(posedge clk);
            start_flush(A'($urandom_range(0, 15)));
            wait_idle(600);
        end

        // Backpressure: valid held with stable payload for five cycles
        ready_mode = 2;
        rsp_rand   = 1'b0;
        rsp_fixed  = 2;
        start_flush(4'b1010);
        n = 0;
        while (!req_valid_o && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("bp_valid_up", req_valid_o, 1);
        h0 = hs_total;
        repeat (5) @(negedge clk);
        #1;
        check("bp_no_hs", hs_total, h0);
        check("bp_valid_held", req_valid_o, 1);
        ready_mode = 0;
        @(negedge clk); #1;
        check("bp_one_hs", hs_total, h0 + 1);
        wait_idle(300);

        // Outstanding limit: no responses until released
        ready_mode = 0;
        rsp_hold   = 1'b1;
        rsp_fixed  = 1;
        start_flush(4'b1111);
        repeat (8) @(negedge clk);
        #1;
        check("lim_valid_low", req_valid_o, 0);
        check("lim_hs", flush_hs, MAXO);
        check("lim_busy", busy_o, 1);
        rsp_hold = 1'b0;
        n = 0;
        while (flush_hs <= MAXO && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("lim_resume", flush_hs > MAXO, 1);
        wait_idle(300);

        // Empty mask: done the cycle after start, no requests
        h0 = hs_total;
        start_flush(4'b0000);
        wait_idle(20);
        check("empty_no_req", hs_total, h0);

        // Spurious response while idle sets the sticky error
        @(negedge clk); #1;
        spur_pulse = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("spur_err", err_o, 1);
        rsp_fixed = 2;
        start_flush(4'b0001);
        check("spur_err_clear", err_o, 0);
        wait_idle(300);

        // Reset while issuing line 2, then a fresh flush from line 0
        ready_mode = 0;
        rsp_rand   = 1'b1;
        start_flush(4'b1111);
        n = 0;
        while (flush_hs < 9 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst_reached_l2", flush_hs >= 9, 1);
        #2 rst_i = 1'b1;
        #1;
        check("rst_async_valid", req_valid_o, 0);
        check("rst_async_busy", busy_o, 0);
        check("rst_async_line", req_line_o, 0);
        repeat (2) @(posedge clk);
        #2 rst_i = 1'b0;
        start_flush(4'b0110);
        wait_idle(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_llc_flush_seq.md
AXI_LLC_FLUSH_SEQ -- requirements
Module: axi_llc_flush_seq

Interface
REQ-001 SHALL have parameter SetAssociativity, default 8, the number of data ways (1..32).
REQ-002 SHALL have parameter NumLines, default 256, the lines per way (power of two, >=2).
REQ-003 SHALL have parameter MaxOutstanding, default 4, the maximum issued-but-unanswered requests (>=1).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port start_i, input, 1 bit: flush start pulse.
REQ-007 SHALL have port way_mask_i, input, SetAssociativity bits: the ways to flush, sampled on an accepted start.
REQ-008 SHALL have port req_valid_o, output, 1 bit: a way read request is valid.
REQ-009 SHALL have port req_ready_i, input, 1 bit: the data way crossbar accepts the request.
REQ-010 SHALL have port req_way_ind_o, output, SetAssociativity bits: one-hot target way.
REQ-011 SHALL have port req_line_o, output, $clog2(NumLines) bits: the line index.
REQ-012 SHALL have port rsp_i, input, 1 bit: one read response consumed by the evict path this cycle.
REQ-013 SHALL have port busy_o, output, 1 bit: the sequencer is not idle.
REQ-014 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port err_o, output, 1 bit: sticky flag for a response with no outstanding request.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-017 SHALL, in IDLE with start_i=1, latch way_mask_i, clear the line and way counters and err_o, and go to ISSUE; if the latched mask is zero, SHALL go to DONE instead.
REQ-018 SHALL ignore start_i in every state other than IDLE.
REQ-019 SHALL, in ISSUE, drive req_way_ind_o as the one-hot of the current way, which is the lowest set bit of the latched mask at or above the way counter.
REQ-020 SHALL, in ISSUE, drive req_line_o from the line counter.
REQ-021 SHALL issue requests line-major: line 0 over all masked ways in ascending order, then line 1, and so on.
REQ-022 SHALL raise req_valid_o in ISSUE only when outstanding < MaxOutstanding.
REQ-023 SHALL, once req_valid_o is high, hold it and the payload stable until req_ready_i (AXI valid/ready rule), regardless of outstanding.
REQ-024 SHALL, on a handshake, advance to the next masked way; past the highest masked way, SHALL wrap to the lowest masked way and increment the line counter.
REQ-025 SHALL go to DRAIN on the handshake for the last masked way of line NumLines-1.
REQ-026 SHALL count outstanding requests as: +1 per handshake, -1 per rsp_i, unchanged when both occur in the same cycle; the counter width SHALL be $clog2(MaxOutstanding+1).
REQ-027 SHALL, on rsp_i with outstanding=0 and no same-cycle handshake, set err_o and leave the counter at 0 (no underflow); err_o SHALL stay set until the next accepted start.
REQ-028 SHALL leave DRAIN for DONE in the cycle after outstanding reaches 0.
REQ-029 SHALL assert done_o for exactly one cycle in DONE, then go to IDLE.
REQ-030 SHALL assert busy_o in ISSUE, DRAIN and DONE.
REQ-031 SHALL have no combinational path from req_ready_i or rsp_i to req_valid_o.
REQ-032 SHALL issue a total of popcount(mask)*NumLines requests per flush.

Reset
REQ-033 SHALL, on rst_i=1 at any time, take state to IDLE asynchronously and clear all counters, the latched mask and err_o.
REQ-034 SHALL hold every output at 0 during reset, including req_way_ind_o and req_line_o.
REQ-035 SHALL abandon any flush in progress on reset, without emitting a done_o pulse.

Structure
REQ-036 SHALL take the state enum from axi_llc_pkg as flush_state_e.
REQ-037 SHALL use a single sub-module, lzc, for the next-masked-way search; all other logic SHALL be local.

Verification
REQ-038 SHALL cover a basic flush: Assoc=4, NumLines=4, Max=2, mask=4'b0101, ready=1, rsp 2 cycles after each request -> 8 requests in the order (l0,w0),(l0,w2),(l1,w0)...(l3,w2), then one done_o pulse.
REQ-039 SHALL cover backpressure: ready=0 for 5 cycles with valid high -> payload stable and exactly one request counted on release.
REQ-040 SHALL cover the outstanding limit: no rsp_i after 2 handshakes -> req_valid_o low until rsp_i, then resumes; simultaneous handshake and rsp_i leave the count unchanged.
REQ-041 SHALL cover an empty mask: start with mask=0 -> done_o 1 cycle later and zero requests.
REQ-042 SHALL cover a spurious response: rsp_i while idle -> err_o=1, which clears on the next start.
REQ-043 SHALL cover reset mid-operation: rst_i during ISSUE at line 2 -> IDLE with outputs 0, no done_o, and a fresh start restarting at line 0.
